// File: rtl/mul8u_prod_accum.sv
// Streaming accumulator for 16-bit approximate-multiplier products.
// Sums a last-delimited packet and holds the sum, term count and saturation flag until the consumer takes them.
//
// state | meaning
// IDLE  | no packet in progress, ready for the first beat
// ACCUM | packet in progress, acc/cnt/sat hold partial values
// HOLD  | result presented on out_*, input side stalled
module mul8u_prod_accum #(
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_prod,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_cnt,
    output logic             out_sat
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             sat;
    logic             accept;
    logic [ACC_W:0]   nsum_wide;
    logic [ACC_W-1:0] sum_new;
    logic [CNT_W-1:0] cnt_new;
    logic             sat_new;

    assign accept = in_valid & in_ready;

    // The extra carry bit of nsum_wide flags overflow; the sum then clips to all-ones.
    always_comb begin
        nsum_wide = {1'b0, acc} + {{(ACC_W - 15){1'b0}}, in_prod};
        sum_new   = nsum_wide[ACC_W] ? {ACC_W{1'b1}} : nsum_wide[ACC_W-1:0];
        sat_new   = sat | nsum_wide[ACC_W];
        cnt_new   = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + {{(CNT_W - 1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, ACCUM: begin
                if (accept) begin
                    state_nxt = in_last ? HOLD : ACCUM;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state != HOLD);
        out_valid = (state == HOLD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            cnt     <= '0;
            sat     <= 1'b0;
            out_sum <= '0;
            out_cnt <= '0;
            out_sat <= 1'b0;
        end else if (accept) begin
            if (in_last) begin
                out_sum <= sum_new;
                out_cnt <= cnt_new;
                out_sat <= sat_new;
                acc     <= '0;
                cnt     <= '0;
                sat     <= 1'b0;
            end else begin
                acc <= sum_new;
                cnt <= cnt_new;
                sat <= sat_new;
            end
        end
    end

endmodule
